branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 106 ++++++++++
 tb/tb_branch_predictor.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup in IF is purely combinational; resolution and training happen in EX.
module branch_predictor #(
  parameter int INDEX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC_IF,
  output logic        predict_br_IF,
  output logic        BHT_predict_IF,
  output logic [31:0] predict_target_IF,
  input  logic        ex_valid,
  input  logic [31:0] PC_EX,
  input  logic        is_br_EX,
  input  logic        br_taken_EX,
  input  logic [31:0] br_target_EX,
  input  logic        predict_br_EX,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_count,
  output logic [31:0] miss_count
);

  localparam int ENTRIES = 1 << INDEX_W;
  localparam int TAG_W   = 30 - INDEX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [INDEX_W-1:0] idx_if, idx_ex;
  logic [TAG_W-1:0]   tag_if, tag_ex;
  logic               hit_if, hit_ex;
  logic               br_upd, alias_hit, dir_wrong, tgt_wrong;
  logic               unused_pc_bits;

  assign idx_if = PC_IF[INDEX_W+1:2];
  assign tag_if = PC_IF[31:INDEX_W+2];
  assign idx_ex = PC_EX[INDEX_W+1:2];
  assign tag_ex = PC_EX[31:INDEX_W+2];
  assign unused_pc_bits = ^{PC_IF[1:0], PC_EX[1:0]};

  // Fetch-side lookup sees only registered state, so updates appear next cycle.
  always_comb begin
    hit_if            = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
    BHT_predict_IF    = !rst && ctr_q[idx_if][1];
    predict_br_IF     = !rst && hit_if && ctr_q[idx_if][1];
    predict_target_IF = predict_br_IF ? target_q[idx_if] : 32'd0;
  end

  // A non-branch that was predicted taken can only come from a tag alias.
  always_comb begin
    hit_ex      = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);
    br_upd      = ex_valid && is_br_EX;
    alias_hit   = ex_valid && !is_br_EX && predict_br_EX;
    dir_wrong   = predict_br_EX != br_taken_EX;
    tgt_wrong   = predict_br_EX && br_taken_EX && (target_q[idx_ex] != br_target_EX);
    mispredict  = (br_upd && (dir_wrong || tgt_wrong)) || alias_hit;
    redirect_pc = 32'd0;
    if (mispredict) begin
      redirect_pc = (is_br_EX && br_taken_EX) ? br_target_EX : PC_EX + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      br_count   <= 32'd0;
      miss_count <= 32'd0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        ctr_q[i]    <= 2'd1;
      end
    end else begin
      if (br_upd) begin
        br_count <= br_count + 32'd1;
      end
      if (mispredict) begin
        miss_count <= miss_count + 32'd1;
      end
      // Not-taken misses are not allocated; they would only pollute the table.
      if (br_upd) begin
        if (hit_ex) begin
          if (br_taken_EX) begin
            target_q[idx_ex] <= br_target_EX;
            if (ctr_q[idx_ex] != 2'd3) begin
              ctr_q[idx_ex] <= ctr_q[idx_ex] + 2'd1;
            end
          end else if (ctr_q[idx_ex] != 2'd0) begin
            ctr_q[idx_ex] <= ctr_q[idx_ex] - 2'd1;
          end
        end else if (br_taken_EX) begin
          valid_q[idx_ex]  <= 1'b1;
          tag_q[idx_ex]    <= tag_ex;
          target_q[idx_ex] <= br_target_EX;
          ctr_q[idx_ex]    <= 2'd2;
        end
      end else if (alias_hit) begin
        valid_q[idx_ex] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random
// traffic compared against a table-level behavioural model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC_IF;
  logic        predict_br_IF, BHT_predict_IF;
  logic [31:0] predict_target_IF;
  logic        ex_valid, is_br_EX, br_taken_EX, predict_br_EX;
  logic [31:0] PC_EX, br_target_EX;
  logic        mispredict;
  logic [31:0] redirect_pc, br_count, miss_count;

  int n_vec  = 0;
  int n_miss = 0;

  // Behavioural model: 64 slots addressed by word address modulo 64.
  bit          m_valid  [64];
  logic [31:0] m_tag    [64];
  logic [31:0] m_target [64];
  int          m_ctr    [64];
  logic [31:0] m_br, m_mp;

  branch_predictor #(.INDEX_W(6)) dut (
    .clk(clk), .rst(rst), .PC_IF(PC_IF),
    .predict_br_IF(predict_br_IF), .BHT_predict_IF(BHT_predict_IF),
    .predict_target_IF(predict_target_IF),
    .ex_valid(ex_valid), .PC_EX(PC_EX), .is_br_EX(is_br_EX),
    .br_taken_EX(br_taken_EX), .br_target_EX(br_target_EX),
    .predict_br_EX(predict_br_EX), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .br_count(br_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  function automatic int unsigned m_idx(logic [31:0] pc);
    return (pc / 4) % 64;
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == pc / 256);
  endfunction

  function automatic bit exp_pred(logic [31:0] pc);
    return !rst && m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
  endfunction

  function automatic bit exp_bht(logic [31:0] pc);
    return !rst && (m_ctr[m_idx(pc)] >= 2);
  endfunction

  function automatic bit exp_mp();
    if (!ex_valid) return 1'b0;
    if (!is_br_EX) return predict_br_EX;
    if (predict_br_EX != br_taken_EX) return 1'b1;
    return predict_br_EX && br_taken_EX && (m_target[m_idx(PC_EX)] != br_target_EX);
  endfunction

  function automatic logic [31:0] exp_redirect();
    if (!exp_mp()) return 32'd0;
    if (is_br_EX && br_taken_EX) return br_target_EX;
    return PC_EX + 32'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 32'd0; m_target[i] = 32'd0; m_ctr[i] = 1;
    end
    m_br = 32'd0; m_mp = 32'd0;
  endtask

  // Advance one clock and apply the same edge to the model using pre-edge state.
  task automatic cycle();
    int unsigned i;
    bit hit, mp;
    @(posedge clk);
    i = m_idx(PC_EX); hit = m_hit(PC_EX); mp = exp_mp();
    if (rst) begin
      model_reset();
    end else if (ex_valid) begin
      if (mp) m_mp = m_mp + 32'd1;
      if (is_br_EX) begin
        m_br = m_br + 32'd1;
        if (hit) begin
          if (br_taken_EX) begin
            m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
            m_target[i] = br_target_EX;
          end else begin
            m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
          end
        end else if (br_taken_EX) begin
          m_valid[i] = 1'b1; m_tag[i] = PC_EX / 256;
          m_target[i] = br_target_EX; m_ctr[i] = 2;
        end
      end else if (predict_br_EX) begin
        m_valid[i] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic br,
                       input logic tk, input logic [31:0] tgt, input logic pr);
    ex_valid = v; PC_EX = pc; is_br_EX = br; br_taken_EX = tk;
    br_target_EX = tgt; predict_br_EX = pr;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; PC_IF = 32'h100;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle(); cycle();
    if (BHT_predict_IF !== 1'b0) begin n_miss++; $display("[TB] FAIL rst_bht: got %b want 0", BHT_predict_IF); end
    n_vec++;
    rst = 1'b0; #1;
    if (predict_br_IF !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_pred: got %b want 0", predict_br_IF); end
    n_vec++;
    if (BHT_predict_IF !== 1'b0) begin n_miss++; $display("[TB] FAIL reset_bht: got %b want 0", BHT_predict_IF); end
    n_vec++;
    if (predict_target_IF !== 32'h0) begin n_miss++; $display("[TB] FAIL reset_tgt: got %h want 0", predict_target_IF); end
    n_vec++;
    if (br_count !== 32'h0 || miss_count !== 32'h0) begin
      n_miss++; $display("[TB] FAIL reset_counts: got %0d/%0d want 0/0", br_count, miss_count);
    end
    n_vec++;
  endtask

  task automatic test_allocate();
    PC_IF = 32'h100;
    drive(1'b1, 32'h100, 1'b1, 1'b1, 32'h80, 1'b0);
    if (mispredict !== 1'b1 || redirect_pc !== 32'h80) begin
      n_miss++; $display("[TB] FAIL alloc_mp: got %b/%h want 1/00000080", mispredict, redirect_pc);
    end
    n_vec++;
    if (predict_br_IF !== 1'b0) begin n_miss++; $display("[TB] FAIL no_bypass: got %b want 0", predict_br_IF); end
    n_vec++;
    cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    if (miss_count !== 32'd1 || br_count !== 32'd1) begin
      n_miss++; $display("[TB] FAIL alloc_counts: got %0d/%0d want 1/1", br_count, miss_count);
    end
    n_vec++;
    if (predict_br_IF !== 1'b1 || predict_target_IF !== 32'h80) begin
      n_miss++; $display("[TB] FAIL alloc_lookup: got %b/%h want 1/00000080", predict_br_IF, predict_target_IF);
    end
    n_vec++;
  endtask

  task automatic test_counter();
    logic       pr_seq [3] = '{1'b0, 1'b0, 1'b1};
    logic       mp_seq [3] = '{1'b1, 1'b1, 1'b0};
    PC_IF = 32'h100;
    drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h80, 1'b1);
    if (mispredict !== 1'b1 || redirect_pc !== 32'h104) begin
      n_miss++; $display("[TB] FAIL nt1: got %b/%h want 1/00000104", mispredict, redirect_pc);
    end
    n_vec++;
    cycle();
    drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h80, 1'b0);
    if (predict_br_IF !== 1'b0 || mispredict !== 1'b0) begin
      n_miss++; $display("[TB] FAIL nt2: got pred %b mp %b want 0/0", predict_br_IF, mispredict);
    end
    n_vec++;
    cycle();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h100, 1'b1, 1'b1, 32'h80, pr_seq[k]);
      if (predict_br_IF !== pr_seq[k] || mispredict !== mp_seq[k]) begin
        n_miss++; $display("[TB] FAIL taken%0d: got pred %b mp %b want %b/%b", k, predict_br_IF, mispredict, pr_seq[k], mp_seq[k]);
      end
      n_vec++;
      cycle();
    end
    // Counter at 3: one not-taken must still leave a taken prediction.
    drive(1'b1, 32'h100, 1'b1, 1'b0, 32'h80, 1'b1);
    cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    if (predict_br_IF !== 1'b1 || BHT_predict_IF !== 1'b1) begin
      n_miss++; $display("[TB] FAIL ctr_sat: got %b/%b want 1/1", predict_br_IF, BHT_predict_IF);
    end
    n_vec++;
    drive(1'b1, 32'h100, 1'b1, 1'b1, 32'h80, 1'b1);
    cycle();
  endtask

  task automatic test_target_update();
    PC_IF = 32'h100;
    drive(1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b1);
    if (mispredict !== 1'b1 || redirect_pc !== 32'h200) begin
      n_miss++; $display("[TB] FAIL tgt_mp: got %b/%h want 1/00000200", mispredict, redirect_pc);
    end
    n_vec++;
    cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    if (predict_target_IF !== 32'h200) begin
      n_miss++; $display("[TB] FAIL tgt_new: got %h want 00000200", predict_target_IF);
    end
    n_vec++;
  endtask

  task automatic test_alias();
    PC_IF = 32'h100;
    drive(1'b1, 32'h4100, 1'b0, 1'b0, 32'h0, 1'b1);
    if (mispredict !== 1'b1 || redirect_pc !== 32'h4104) begin
      n_miss++; $display("[TB] FAIL alias_mp: got %b/%h want 1/00004104", mispredict, redirect_pc);
    end
    n_vec++;
    cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    if (predict_br_IF !== 1'b0 || BHT_predict_IF !== 1'b1) begin
      n_miss++; $display("[TB] FAIL alias_inval: got %b/%b want 0/1", predict_br_IF, BHT_predict_IF);
    end
    n_vec++;
    drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b1);
    if (mispredict !== 1'b1 || redirect_pc !== 32'h0) begin
      n_miss++; $display("[TB] FAIL wrap: got %b/%h want 1/00000000", mispredict, redirect_pc);
    end
    n_vec++;
    cycle();
  endtask

  task automatic test_ex_invalid();
    PC_IF = 32'h100;
    drive(1'b1, 32'h100, 1'b1, 1'b1, 32'h80, 1'b0);
    cycle();
    drive(1'b0, 32'h100, 1'b1, 1'b0, 32'h300, 1'b1);
    if (mispredict !== 1'b0 || redirect_pc !== 32'h0) begin
      n_miss++; $display("[TB] FAIL exinv_mp: got %b/%h want 0/00000000", mispredict, redirect_pc);
    end
    n_vec++;
    cycle();
    if (br_count !== m_br || miss_count !== m_mp) begin
      n_miss++; $display("[TB] FAIL exinv_counts: got %0d/%0d want %0d/%0d", br_count, miss_count, m_br, m_mp);
    end
    n_vec++;
    if (predict_br_IF !== 1'b1 || predict_target_IF !== 32'h80) begin
      n_miss++; $display("[TB] FAIL exinv_table: got %b/%h want 1/00000080", predict_br_IF, predict_target_IF);
    end
    n_vec++;
  endtask

  task automatic test_reset_priority();
    rst = 1'b1; PC_IF = 32'h300;
    drive(1'b1, 32'h300, 1'b1, 1'b1, 32'h400, 1'b0);
    cycle();
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    if (predict_br_IF !== 1'b0 || BHT_predict_IF !== 1'b0) begin
      n_miss++; $display("[TB] FAIL rstprio_lost: got %b/%b want 0/0", predict_br_IF, BHT_predict_IF);
    end
    n_vec++;
    PC_IF = 32'h100; #1;
    if (predict_br_IF !== 1'b0 || br_count !== 32'h0 || miss_count !== 32'h0) begin
      n_miss++; $display("[TB] FAIL rstprio_clear: got %b %0d/%0d want 0 0/0", predict_br_IF, br_count, miss_count);
    end
    n_vec++;
  endtask

  task automatic test_random();
    logic [31:0] pool [6] = '{32'h100, 32'h4100, 32'h200, 32'h8200, 32'h1FC, 32'hFFFF_FFFC};
    logic [31:0] tgts [4] = '{32'h80, 32'h200, 32'h1000, 32'h2468};
    logic [31:0] pc;
    logic        pr, br;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      PC_IF = ($urandom_range(0, 3) == 0) ? ($urandom & ~32'h3) : pool[$urandom_range(0, 5)];
      pc = ($urandom_range(0, 4) == 0) ? ($urandom & ~32'h3) : pool[$urandom_range(0, 5)];
      br = ($urandom_range(0, 3) != 0);
      pr = ($urandom_range(0, 3) == 0) ? 1'($urandom) : exp_pred(pc);
      drive(($urandom_range(0, 7) != 0), pc, br, 1'($urandom),
            ($urandom_range(0, 4) == 0) ? ($urandom & ~32'h3) : tgts[$urandom_range(0, 3)], pr);
      if (predict_br_IF !== exp_pred(PC_IF) || BHT_predict_IF !== exp_bht(PC_IF)) begin
        n_miss++; $display("[TB] FAIL rnd_lookup @%h: got %b/%b want %b/%b", PC_IF, predict_br_IF, BHT_predict_IF, exp_pred(PC_IF), exp_bht(PC_IF));
      end
      n_vec++;
      if (predict_target_IF !== (exp_pred(PC_IF) ? m_target[m_idx(PC_IF)] : 32'h0)) begin
        n_miss++; $display("[TB] FAIL rnd_target @%h: got %h", PC_IF, predict_target_IF);
      end
      n_vec++;
      if (mispredict !== exp_mp() || redirect_pc !== exp_redirect()) begin
        n_miss++; $display("[TB] FAIL rnd_mp @%h: got %b/%h want %b/%h", PC_EX, mispredict, redirect_pc, exp_mp(), exp_redirect());
      end
      n_vec++;
      cycle();
      if (br_count !== m_br || miss_count !== m_mp) begin
        n_miss++; $display("[TB] FAIL rnd_counts: got %0d/%0d want %0d/%0d", br_count, miss_count, m_br, m_mp);
      end
      n_vec++;
    end
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_allocate();
    test_counter();
    test_target_update();
    test_alias();
    test_ex_invalid();
    test_reset_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
